// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between the EX/MEM register and the 512-byte data memory.
// Latency: store response 2 edges after accept, load 3 edges, fault response next cycle.
// Backpressure: req_ready is high only in IDLE; requests are sampled only on accept.
//
// Ports: clk/rst_n; req_* request side (valid/ready handshake); resp_* registered
// one-cycle completion pulse with fault flag and held load data; mem_* memory pins
// (mem_enable is a one-cycle strobe, all other mem_* held between accepts).
// Optional macro LSU_ALIGN_CHECK_EN: when defined, misaligned halfword/word
// requests are rejected with a fault; otherwise they pass to memory unchanged.
module lsu_mem_ctrl #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    output logic              resp_valid,
    output logic              resp_fault,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              mem_enable,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_size,
    output logic              mem_sign,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETUP   = 2'd1,
        S_STROBE  = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_fault_q, resp_fault_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              mem_enable_q, mem_enable_d;
    logic              mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]        mem_size_q, mem_size_d;
    logic              mem_sign_q, mem_sign_d;

    logic [1:0]        bytes_m1;
    logic [ADDR_W:0]   last_byte;
    logic              size_fault, range_fault, align_fault, any_fault;
    logic              accept;

    // Offset of the last byte touched; size 11 is rejected separately.
    always_comb begin
        bytes_m1 = 2'd0;
        case (req_size)
            2'b01:   bytes_m1 = 2'd1;
            2'b10:   bytes_m1 = 2'd3;
            default: bytes_m1 = 2'd0;
        endcase
    end

    // One extra bit so an access running past the top of memory shows up as a
    // carry instead of wrapping to low addresses.
    assign last_byte   = {1'b0, req_addr} + {{(ADDR_W-1){1'b0}}, bytes_m1};
    assign size_fault  = (req_size == 2'b11);
    assign range_fault = last_byte[ADDR_W];

`ifdef LSU_ALIGN_CHECK_EN
    assign align_fault = ((req_size == 2'b01) && req_addr[0]) ||
                         ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign align_fault = 1'b0;
`endif

    assign any_fault = size_fault || range_fault || align_fault;
    assign req_ready = (state_q == S_IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d      = state_q;
        resp_valid_d = 1'b0;
        resp_fault_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        mem_enable_d = 1'b0;
        mem_rw_d     = mem_rw_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_size_d   = mem_size_q;
        mem_sign_d   = mem_sign_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (any_fault) begin
                        // Rejected: memory pins untouched, respond next cycle.
                        resp_valid_d = 1'b1;
                        resp_fault_d = 1'b1;
                    end else begin
                        mem_rw_d    = req_write;
                        mem_addr_d  = req_addr;
                        mem_wdata_d = req_wdata;
                        mem_size_d  = req_size;
                        mem_sign_d  = req_signed;
                        state_d     = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                // Address/data have now been stable a full cycle; raise the strobe.
                mem_enable_d = 1'b1;
                state_d      = S_STROBE;
            end
            S_STROBE: begin
                if (mem_rw_q) begin
                    resp_valid_d = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                resp_rdata_d = mem_rdata;
                resp_valid_d = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= '0;
            mem_enable_q <= 1'b0;
            mem_rw_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_size_q   <= 2'b00;
            mem_sign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_fault_q <= resp_fault_d;
            resp_rdata_q <= resp_rdata_d;
            mem_enable_q <= mem_enable_d;
            mem_rw_q     <= mem_rw_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_size_q   <= mem_size_d;
            mem_sign_q   <= mem_sign_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_fault = resp_fault_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_enable = mem_enable_q;
    assign mem_rw     = mem_rw_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_size   = mem_size_q;
    assign mem_sign   = mem_sign_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Testbench for lsu_mem_ctrl: behavioural 512-byte memory acting on the rising
// edge of mem_enable, scoreboard queue filled at accept, monitor checking responses.
// Directed vectors with hand-computed expected data.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [8:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        req_signed = 1'b0;
    logic        resp_valid;
    logic        resp_fault;
    logic [31:0] resp_rdata;
    logic        mem_enable;
    logic        mem_rw;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_size;
    logic        mem_sign;
    logic [31:0] mem_rdata = '0;

    lsu_mem_ctrl #(.ADDR_W(9), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_signed(req_signed),
        .resp_valid(resp_valid), .resp_fault(resp_fault), .resp_rdata(resp_rdata),
        .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_sign(mem_sign),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nchk = 0;
    int nerr = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural byte-addressed memory, little-endian, sign-extends loads itself.
    logic [7:0] mem [512];
    int strobes = 0;
    int exp_strobes = 0;
    initial for (int i = 0; i < 512; i++) mem[i] = i[7:0];

    always @(posedge mem_enable) begin
        int nb;
        logic [31:0] v;
        logic [8:0]  ai;
        strobes++;
        nb = (mem_size == 2'b00) ? 1 : (mem_size == 2'b01) ? 2 : 4;
        v = '0;
        for (int i = 0; i < nb; i++) begin
            ai = mem_addr + 9'(i);
            if (mem_rw) mem[ai] = mem_wdata[8*i +: 8];
            else        v[8*i +: 8] = mem[ai];
        end
        if (!mem_rw) begin
            if (mem_sign && nb == 1) v[31:8]  = {24{v[7]}};
            if (mem_sign && nb == 2) v[31:16] = {16{v[15]}};
            mem_rdata <= v;
        end
    end

    // Scoreboard
    typedef struct {
        logic        fault;
        logic [31:0] rdata;
        int          lat;
        int          acc;
    } exp_t;
    exp_t        sb[$];
    logic [31:0] last_rdata = '0;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && resp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", {95'd0, resp_valid}, 96'd0);
            end else begin
                e = sb.pop_front();
                check("resp_fault", {95'd0, resp_fault}, {95'd0, e.fault});
                check("resp_rdata", {64'd0, resp_rdata}, {64'd0, e.rdata});
                check("resp_latency", 96'(cyc - e.acc), 96'(e.lat));
            end
        end
    end

    // Strobe shape: one cycle wide, pins unchanged from the cycle before.
    logic        prev_en = 1'b0;
    logic [43:0] prev_pins = '0;
    always @(negedge clk) begin
        logic [43:0] pins;
        pins = {mem_rw, mem_size, mem_addr, mem_wdata};
        if (mem_enable) begin
            check("strobe_width", {95'd0, prev_en}, 96'd0);
            check("strobe_setup", {52'd0, pins}, {52'd0, prev_pins});
        end
        prev_en   = mem_enable;
        prev_pins = pins;
    end

    task automatic issue(input logic w, input logic [8:0] a, input logic [31:0] d,
                         input logic [1:0] sz, input logic sg, input logic ef,
                         input logic [31:0] er, input bit hold, output int acc);
        int   n = 0;
        exp_t e;
        acc = -1;
        req_write = w; req_addr = a; req_wdata = d; req_size = sz; req_signed = sg;
        req_valid = 1'b1;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept", {95'd0, req_ready}, 96'd1);
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        if (!ef && !w) last_rdata = er;
        e.fault = ef;
        e.rdata = last_rdata;
        e.lat   = ef ? 0 : (w ? 2 : 3);
        e.acc   = acc;
        sb.push_back(e);
        if (!ef) exp_strobes++;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drain", 96'(sb.size()), 96'd0);
        check("strobe_count", 96'(strobes), 96'(exp_strobes));
    endtask

    initial begin
        int a0, a1;
        logic align_on;
`ifdef LSU_ALIGN_CHECK_EN
        align_on = 1'b1;
`else
        align_on = 1'b0;
`endif
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs",
              {16'd0, resp_valid, resp_fault, mem_enable, mem_rw, mem_sign, mem_size,
               mem_addr, mem_wdata, resp_rdata}, 96'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_ready", {95'd0, req_ready}, 96'd1);

        // Word store then load
        issue(1, 9'h010, 32'hDEADBEEF, 2'b10, 0, 0, 32'h0, 0, a0);
        issue(0, 9'h010, 32'h0,        2'b10, 0, 0, 32'hDEADBEEF, 0, a0);
        // Byte store, signed and unsigned byte loads
        issue(1, 9'h005, 32'hAAAAAA80, 2'b00, 0, 0, 32'h0, 0, a0);
        issue(0, 9'h005, 32'h0,        2'b00, 1, 0, 32'hFFFFFF80, 0, a0);
        issue(0, 9'h005, 32'h0,        2'b00, 0, 0, 32'h00000080, 0, a0);
        drain();
        // Range and size faults, edge-of-memory accesses
        issue(0, 9'h1FD, 32'h0, 2'b10, 0, 1, 32'h0, 0, a0);
        issue(0, 9'h1FF, 32'h0, 2'b01, 0, 1, 32'h0, 0, a0);
        issue(1, 9'h000, 32'h0, 2'b11, 0, 1, 32'h0, 0, a0);
        drain();
        issue(0, 9'h1FF, 32'h0, 2'b00, 0, 0, 32'h000000FF, 0, a0);
        issue(0, 9'h1FC, 32'h0, 2'b10, 0, 0, 32'hFFFEFDFC, 0, a0);
        issue(0, 9'h1FE, 32'h0, 2'b01, 1, 0, 32'hFFFFFFFE, 0, a0);
        // Misaligned accesses
        issue(0, 9'h012, 32'h0, 2'b10, 0, align_on, 32'h1514DEAD, 0, a0);
        issue(0, 9'h011, 32'h0, 2'b01, 0, align_on, 32'h0000ADBE, 0, a0);
        drain();

        // Back-to-back with req_valid held
        issue(1, 9'h030, 32'h0BADF00D, 2'b10, 0, 0, 32'h0, 1, a0);
        issue(0, 9'h030, 32'h0,        2'b10, 0, 0, 32'h0BADF00D, 0, a1);
        check("b2b_spacing", 96'(a1 - a0), 96'd3);
        check("ready_setup", {95'd0, req_ready}, 96'd0);
        @(posedge clk); #1;
        check("ready_strobe", {95'd0, req_ready}, 96'd0);
        @(posedge clk); #1;
        check("ready_capture", {95'd0, req_ready}, 96'd0);
        @(posedge clk); #1;
        check("ready_resp", {95'd0, req_ready}, 96'd1);
        drain();

        // Reset during SETUP of a store
        req_write = 1; req_addr = 9'h020; req_wdata = 32'h12345678;
        req_size = 2'b10; req_signed = 0; req_valid = 1;
        @(posedge clk); #1;
        req_valid = 0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs",
              {16'd0, resp_valid, resp_fault, mem_enable, mem_rw, mem_sign, mem_size,
               mem_addr, mem_wdata, resp_rdata}, 96'd0);
        last_rdata = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("midreset_no_strobe", 96'(strobes), 96'(exp_strobes));
        issue(0, 9'h020, 32'h0, 2'b10, 0, 0, 32'h23222120, 0, a0);
        drain();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
